uart_avs_responder: RTL and testbench



---
 rtl/uart_avs_responder_pkg.sv | 25 ++
 rtl/uart_avs_responder_if.sv | 22 ++
 rtl/uart_rx_deser.sv | 98 +++++++++
 rtl/uart_avs_responder.sv | 192 +++++++++++++++++++
 tb/tb_uart_avs_responder.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_avs_responder_pkg.sv
// Shared constants and types for the UART Avalon-MM responder: register
// offsets, STATUS bit positions, bus widths and the serial FSM state type.
package uart_avs_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  localparam logic [ADDR_W-1:0] RX_BASE     = 5'd0;
  localparam logic [ADDR_W-1:0] TX_BASE     = 5'd4;
  localparam logic [ADDR_W-1:0] STATUS_BASE = 5'd8;
  localparam logic [ADDR_W-1:0] CTRL_BASE   = 5'd12;

  localparam int RRDY_BIT = 7;
  localparam int TRDY_BIT = 6;
  localparam int ROE_BIT  = 3;
  localparam int FE_BIT   = 2;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } serial_state_e;

endpackage

// File: rtl/uart_avs_responder_if.sv
// Avalon-MM slave bus bundle for the UART responder; the master modport is
// the bus side (host-link master or bench), the slave modport the responder.
interface uart_avs_responder_if;
  import uart_avs_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              read;
  logic [DATA_W-1:0] readdata;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;

  modport master (
    output address, read, write, writedata,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, read, write, writedata,
    output readdata, waitrequest
  );
endinterface

// File: rtl/uart_rx_deser.sv
// 8N1 serial receiver: 2-flop synchronizer, mid-bit sampling timer and RX
// FSM. Emits the byte with a one-cycle valid and a stop-bit framing error.
module uart_rx_deser
  import uart_avs_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       avm_clk,
  input  logic       avm_rst,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [1:0]    sync_q;
  logic          rx_s;
  serial_state_e state, state_next;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          cnt_clr;
  logic          shift_en;
  logic          done;

  // Idle-high reset keeps a line held low during reset from faking a start bit.
  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) sync_q <= 2'b11;
    else         sync_q <= {sync_q[0], rxd};
  end

  assign rx_s = sync_q[1];

  // NOTE: every output of a combinational block gets a default before the
  // case so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    cnt_clr    = 1'b0;
    shift_en   = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (!rx_s) state_next = START;
      end
      START: begin
        if (cnt == HALF) begin
          cnt_clr    = 1'b1;
          state_next = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == LAST) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (bit_idx == 3'd7) state_next = STOP;
        end
      end
      STOP: begin
        if (cnt == LAST) begin
          cnt_clr    = 1'b1;
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_clr ? '0 : cnt + 1'b1;
      if (state == IDLE)  bit_idx <= '0;
      else if (shift_en)  bit_idx <= bit_idx + 1'b1;
      if (shift_en) shift <= {rx_s, shift[7:1]};
      valid     <= done;
      frame_err <= done & ~rx_s;
    end
  end

  // The shift register is untouched until the next frame's first data bit.
  assign data = shift;

endmodule

// File: rtl/uart_avs_responder.sv
// UART Avalon-MM responder: RX/TX/STATUS register map over an 8N1 receiver
// and transmitter. Define UART_LOOPBACK_EN to add the CTRL loopback register.
module uart_avs_responder
  import uart_avs_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BAUD         = 115_200,
  parameter int CLKS_PER_BIT = (CLK_HZ + BAUD / 2) / BAUD
) (
  input  logic                 avm_clk,
  input  logic                 avm_rst,
  uart_avs_responder_if.slave  avs,
  input  logic                 uart_rxd,
  output logic                 uart_txd
);

  if (CLKS_PER_BIT < 4) begin : g_cpb_check
    $error("uart_avs_responder: CLKS_PER_BIT must be >= 4");
  end

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic ack_q;
  logic req, wr_only, tx_stall;
  logic rd_ack, wr_ack, rx_rd_ack, tx_load, status_wr;
  logic [DATA_W-1:0] rd_data;

  logic [7:0] rx_byte;
  logic       rrdy, roe, fe, trdy;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ferr, rx_in;

  serial_state_e tx_state, tx_next;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift, tx_shift_next;
  logic          tx_line, tx_line_next;
  logic          tx_cnt_clr, tx_shift_en;

  logic unused_wdata;
  assign unused_wdata = ^avs.writedata[DATA_W-1:8];

  // Bus handshake: one wait cycle, then a single ack cycle; a TX write is
  // held off while a frame is still on the line.
  assign req      = avs.read | avs.write;
  assign wr_only  = avs.write & ~avs.read;
  assign trdy     = (tx_state == IDLE);
  assign tx_stall = wr_only & (avs.address == TX_BASE) & ~trdy;

  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) ack_q <= 1'b0;
    else         ack_q <= req & ~ack_q & ~tx_stall;
  end

  assign avs.waitrequest = ~ack_q;
  assign rd_ack    = ack_q & avs.read;
  assign wr_ack    = ack_q & wr_only;
  assign rx_rd_ack = rd_ack & (avs.address == RX_BASE);
  assign tx_load   = wr_ack & (avs.address == TX_BASE);
  assign status_wr = wr_ack & (avs.address == STATUS_BASE);

`ifdef UART_LOOPBACK_EN
  logic loop;

  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst)                                    loop <= 1'b0;
    else if (wr_ack && avs.address == CTRL_BASE)    loop <= avs.writedata[0];
  end

  assign rx_in    = loop ? tx_line : uart_rxd;
  assign uart_txd = loop ? 1'b1 : tx_line;
`else
  assign rx_in    = uart_rxd;
  assign uart_txd = tx_line;
`endif

  // Read data is driven only in the ack cycle, straight from live state.
  always_comb begin
    rd_data = '0;
    if (rd_ack) begin
      case (avs.address)
        RX_BASE: rd_data[7:0] = rx_byte;
        STATUS_BASE: begin
          rd_data[RRDY_BIT] = rrdy;
          rd_data[TRDY_BIT] = trdy;
          rd_data[ROE_BIT]  = roe;
          rd_data[FE_BIT]   = fe;
        end
`ifdef UART_LOOPBACK_EN
        CTRL_BASE: rd_data[0] = loop;
`endif
        default: rd_data = '0;
      endcase
    end
  end

  assign avs.readdata = rd_data;

  uart_rx_deser #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .avm_clk   (avm_clk),
    .avm_rst   (avm_rst),
    .rxd       (rx_in),
    .data      (rx_data),
    .valid     (rx_valid),
    .frame_err (rx_ferr)
  );

  // A completing byte wins over a same-cycle RX read clear; that read
  // consumed the old byte, so it is not counted as an overrun.
  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      rx_byte <= '0;
      rrdy    <= 1'b0;
      roe     <= 1'b0;
      fe      <= 1'b0;
    end else begin
      if (rx_rd_ack) rrdy <= 1'b0;
      if (status_wr) begin
        roe <= 1'b0;
        fe  <= 1'b0;
      end
      if (rx_valid) begin
        rx_byte <= rx_data;
        rrdy    <= 1'b1;
        if (rrdy && !rx_rd_ack) roe <= 1'b1;
        if (rx_ferr)            fe  <= 1'b1;
      end
    end
  end

  always_comb begin
    tx_next     = tx_state;
    tx_cnt_clr  = 1'b0;
    tx_shift_en = 1'b0;
    case (tx_state)
      IDLE: begin
        tx_cnt_clr = 1'b1;
        if (tx_load) tx_next = START;
      end
      START: begin
        if (tx_cnt == LAST) begin
          tx_cnt_clr = 1'b1;
          tx_next    = DATA;
        end
      end
      DATA: begin
        if (tx_cnt == LAST) begin
          tx_cnt_clr  = 1'b1;
          tx_shift_en = 1'b1;
          if (tx_bit == 3'd7) tx_next = STOP;
        end
      end
      STOP: begin
        if (tx_cnt == LAST) begin
          tx_cnt_clr = 1'b1;
          tx_next    = IDLE;
        end
      end
      default: tx_next = IDLE;
    endcase

    tx_shift_next = tx_shift;
    if (tx_state == IDLE && tx_load) tx_shift_next = avs.writedata[7:0];
    else if (tx_shift_en)            tx_shift_next = {1'b0, tx_shift[7:1]};

    // The line is registered from next-state values so uart_txd is glitch-free.
    case (tx_next)
      START:   tx_line_next = 1'b0;
      DATA:    tx_line_next = tx_shift_next[0];
      default: tx_line_next = 1'b1;
    endcase
  end

  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_line  <= 1'b1;
    end else begin
      tx_state <= tx_next;
      tx_cnt   <= tx_cnt_clr ? '0 : tx_cnt + 1'b1;
      if (tx_state == IDLE)  tx_bit <= '0;
      else if (tx_shift_en)  tx_bit <= tx_bit + 1'b1;
      tx_shift <= tx_shift_next;
      tx_line  <= tx_line_next;
    end
  end

endmodule

// File: tb/tb_uart_avs_responder.sv
// Directed self-checking bench for uart_avs_responder at 10 clocks per bit:
// register map, handshake timing, TX framing, RX status flags, reset, loopback.
module tb_uart_avs_responder;
  import uart_avs_pkg::*;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int CPB    = 10;

  logic avm_clk = 1'b0;
  logic avm_rst;
  logic uart_rxd;
  logic uart_txd;

  uart_avs_responder_if avs ();

  uart_avs_responder #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) dut (
    .avm_clk  (avm_clk),
    .avm_rst  (avm_rst),
    .avs      (avs),
    .uart_rxd (uart_rxd),
    .uart_txd (uart_txd)
  );

  always #5 avm_clk = ~avm_clk;

  int n_checks = 0;
  int n_fails  = 0;

  logic [31:0] exp_rd_q[$];
  logic        exp_bit_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one request from just after a rising edge; return read data and
  // the number of cycles waitrequest was seen high.
  task automatic bus_xfer(input logic rd, input logic wr, input logic [4:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output int waits);
    @(posedge avm_clk);
    #1;
    avs.read      = rd;
    avs.write     = wr;
    avs.address   = addr;
    avs.writedata = wdata;
    waits = 0;
    @(negedge avm_clk);
    while (avs.waitrequest !== 1'b0 && waits < 400) begin
      waits++;
      @(negedge avm_clk);
    end
    if (avs.waitrequest !== 1'b0) check("bus ack timeout", 32'(waits), 32'd0);
    rdata = avs.readdata;
    @(posedge avm_clk);
    #1;
    avs.read  = 1'b0;
    avs.write = 1'b0;
  endtask

  task automatic expect_read(input logic [4:0] addr, input logic [31:0] exp,
                             input string tag, output int waits);
    logic [31:0] rdata;
    exp_rd_q.push_back(exp);
    bus_xfer(1'b1, 1'b0, addr, 32'd0, rdata, waits);
    check(tag, rdata, exp_rd_q.pop_front());
  endtask

  task automatic bus_write(input logic [4:0] addr, input logic [31:0] data, output int waits);
    logic [31:0] rdata;
    bus_xfer(1'b0, 1'b1, addr, data, rdata, waits);
  endtask

  task automatic push_frame(input logic [7:0] b);
    exp_bit_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bit_q.push_back(b[i]);
    exp_bit_q.push_back(1'b1);
  endtask

  // Find the start bit, then check the first and last cycle of every bit.
  task automatic mon_frame(input string tag, output int lead);
    logic cur;
    cur  = 1'b1;
    lead = 0;
    @(negedge avm_clk);
    while (uart_txd !== 1'b0 && lead < 300) begin
      lead++;
      @(negedge avm_clk);
    end
    if (uart_txd !== 1'b0) begin
      check({tag, " start timeout"}, 32'(uart_txd), 32'd0);
      for (int i = 0; i < 10; i++) void'(exp_bit_q.pop_front());
    end else begin
      for (int c = 1; c <= 10 * CPB; c++) begin
        if (c > 1) @(negedge avm_clk);
        if (c % CPB == 1) cur = exp_bit_q.pop_front();
        if (c % CPB == 1 || c % CPB == 0) check(tag, 32'(uart_txd), 32'(cur));
      end
    end
  endtask

  task automatic drive_bit(input logic v);
    uart_rxd = v;
    repeat (CPB) @(posedge avm_clk);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    @(posedge avm_clk);
    #1;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
    uart_rxd = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w, w2, lead1, lead2, lows;
    logic [31:0] rdata;

    avs.read      = 1'b0;
    avs.write     = 1'b0;
    avs.address   = '0;
    avs.writedata = '0;
    uart_rxd      = 1'b1;
    avm_rst       = 1'b1;

    // Reset state
    repeat (3) @(negedge avm_clk);
    check("rst waitrequest", 32'(avs.waitrequest), 32'd1);
    check("rst readdata", avs.readdata, 32'd0);
    check("rst txd", 32'(uart_txd), 32'd1);
    @(posedge avm_clk);
    #1;
    avm_rst = 1'b0;

    expect_read(STATUS_BASE, 32'h40, "status after reset", w);
    check("read wait cycles", 32'(w), 32'd1);
    @(negedge avm_clk);
    check("waitrequest back high", 32'(avs.waitrequest), 32'd1);
    check("idle txd", 32'(uart_txd), 32'd1);

    // Unmapped and write-only offsets read as zero
    expect_read(TX_BASE, 32'h0, "tx read", w);
    expect_read(5'h10, 32'h0, "unmapped read", w);

    // Read and write together: write must be ignored
    bus_xfer(1'b1, 1'b1, TX_BASE, 32'h55, rdata, w);
    check("rd+wr readdata", rdata, 32'h0);
    expect_read(STATUS_BASE, 32'h40, "rd+wr no tx load", w);

    // TX frame 0xA5 with TRDY boundary
    push_frame(8'hA5);
    bus_write(TX_BASE, 32'hA5, w);
    check("tx write wait", 32'(w), 32'd1);
    fork
      begin
        mon_frame("tx A5 bit", lead1);
        check("tx A5 lead", 32'(lead1), 32'd0);
      end
      begin
        repeat (97) @(posedge avm_clk);
        expect_read(STATUS_BASE, 32'h00, "status at cycle 100", w2);
      end
    join
    expect_read(STATUS_BASE, 32'h40, "status after frame", w);

    // RX single byte
    send_rx(8'h3C, 1'b1);
    expect_read(STATUS_BASE, 32'hC0, "status rx ready", w);
    expect_read(RX_BASE, 32'h3C, "rx data 3C", w);
    expect_read(STATUS_BASE, 32'h40, "status rx cleared", w);

    // Overrun then clear via STATUS write
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    expect_read(STATUS_BASE, 32'hC8, "status overrun", w);
    expect_read(RX_BASE, 32'h22, "rx data overwrite", w);
    bus_write(STATUS_BASE, 32'h0, w);
    expect_read(STATUS_BASE, 32'h40, "status roe cleared", w);

    // Framing error: byte still stored
    send_rx(8'h77, 1'b0);
    repeat (30) @(posedge avm_clk);
    expect_read(STATUS_BASE, 32'hC4, "status frame err", w);
    expect_read(RX_BASE, 32'h77, "rx data bad stop", w);
    bus_write(STATUS_BASE, 32'hFFFF_FFFF, w);
    expect_read(STATUS_BASE, 32'h40, "status fe cleared", w);

    // Back-to-back TX writes: second stalls until TRDY
    push_frame(8'h81);
    push_frame(8'h3C);
    bus_write(TX_BASE, 32'h81, w);
    fork
      begin
        mon_frame("b2b first bit", lead1);
        mon_frame("b2b second bit", lead2);
        check("b2b gap", 32'(lead2), 32'd2);
      end
      begin
        bus_write(TX_BASE, 32'h3C, w2);
        check("b2b stall cycles", 32'(w2), 32'd100);
      end
    join
    expect_read(STATUS_BASE, 32'h40, "status after b2b", w);

    // Reset mid-frame
    bus_write(TX_BASE, 32'h00, w);
    repeat (30) @(posedge avm_clk);
    #2;
    check("txd low mid-frame", 32'(uart_txd), 32'd0);
    #1;
    avm_rst = 1'b1;
    #1;
    check("txd on async reset", 32'(uart_txd), 32'd1);
    check("waitrequest in reset", 32'(avs.waitrequest), 32'd1);
    @(posedge avm_clk);
    #1;
    avm_rst = 1'b0;
    expect_read(STATUS_BASE, 32'h40, "status after reset mid-frame", w);

`ifdef UART_LOOPBACK_EN
    bus_write(CTRL_BASE, 32'h1, w);
    expect_read(CTRL_BASE, 32'h1, "ctrl loop set", w);
    bus_write(TX_BASE, 32'h5A, w);
    lows = 0;
    for (int c = 0; c < 12 * CPB; c++) begin
      @(negedge avm_clk);
      if (uart_txd !== 1'b1) lows++;
    end
    check("loopback txd held high", 32'(lows), 32'd0);
    expect_read(STATUS_BASE, 32'hC0, "loopback status", w);
    expect_read(RX_BASE, 32'h5A, "loopback rx data", w);
    bus_write(CTRL_BASE, 32'h0, w);
    expect_read(CTRL_BASE, 32'h0, "ctrl loop clear", w);
`else
    lows = 0;
    bus_write(CTRL_BASE, 32'h1, w);
    expect_read(CTRL_BASE, 32'h0, "ctrl unmapped", w);
    expect_read(STATUS_BASE, 32'h40, "status after ctrl write", w);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
